// File: rtl/cpu_trace_buffer_pkg.sv
// trace_pkg: capture modes and the retire-trace record layout shared by the trace buffer.
package trace_pkg;
  localparam int TR_XLEN = 32;
  localparam int TR_RA_W = 5;
  localparam int TR_SEQ_W = 16;
  typedef enum logic [1:0] {OFF, STREAM, FLOW, RING} trace_mode_e;
  typedef struct packed {
    logic [TR_XLEN-1:0] pc;
    logic [TR_XLEN-1:0] next_pc;
    logic [TR_RA_W-1:0] rs1;
    logic [TR_RA_W-1:0] rs2;
    logic [TR_RA_W-1:0] rd;
    logic [TR_XLEN-1:0] alu;
    logic [TR_XLEN-1:0] mem_data;
    logic [TR_XLEN-1:0] store_data;
    logic [TR_SEQ_W-1:0] seq;
  } trace_rec_t;
endpackage

// File: rtl/cpu_trace_buffer_mem.sv
// trace_fifo_mem: record storage with one write port and an asynchronous read port.
module trace_fifo_mem import trace_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  trace_rec_t    wd_i,
  input  logic [AW-1:0] ra_i,
  output trace_rec_t    rd_o
);
  trace_rec_t mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[wa_i] <= wd_i;
  assign rd_o = mem_q[ra_i];
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: filters retire records by mode, tags them with a sequence number and queues them
// in a first-word fall-through FIFO with drop-newest or overwrite-oldest overflow.
module cpu_trace_buffer import trace_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_valid_i,
  input  logic [XLEN-1:0]   cap_pc_i,
  input  logic [XLEN-1:0]   cap_next_pc_i,
  input  logic [RA_W-1:0]   cap_rs1_i,
  input  logic [RA_W-1:0]   cap_rs2_i,
  input  logic [RA_W-1:0]   cap_rd_i,
  input  logic [XLEN-1:0]   cap_alu_i,
  input  logic [XLEN-1:0]   cap_mem_data_i,
  input  logic [XLEN-1:0]   cap_store_data_i,
  input  trace_mode_e       mode_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output trace_rec_t        out_rec_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [SEQ_W-1:0]  drop_cnt_o
);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d, drop_q, drop_d;
  logic qual, pop, full, push, ovr, lost, inc, dec;
  trace_rec_t rec;
  assign full = cnt_q == CW'(DEPTH);
  assign pop = out_valid_o && out_ready_i;
  assign qual = cap_valid_i && mode_i != OFF && (mode_i != FLOW || cap_next_pc_i != cap_pc_i + XLEN'(4));
  assign push = qual && !flush_i && (!full || pop || mode_i == RING);
  // a push into a full FIFO without a pop can only be a RING overwrite
  assign ovr = push && full && !pop;
  assign lost = qual && !flush_i && full && !pop;
  assign inc = push && !pop && !ovr;
  assign dec = pop && !push;
  always_comb begin
    rec = '{pc: TR_XLEN'(cap_pc_i), next_pc: TR_XLEN'(cap_next_pc_i), rs1: TR_RA_W'(cap_rs1_i),
            rs2: TR_RA_W'(cap_rs2_i), rd: TR_RA_W'(cap_rd_i), alu: TR_XLEN'(cap_alu_i),
            mem_data: TR_XLEN'(cap_mem_data_i), store_data: TR_XLEN'(cap_store_data_i),
            seq: TR_SEQ_W'(seq_q)};
    wr_d = flush_i ? '0 : wr_q + AW'(push);
    rd_d = flush_i ? '0 : rd_q + AW'(pop || ovr);
    cnt_d = flush_i ? '0 : cnt_q + CW'(inc) - CW'(dec);
    drop_d = flush_i ? '0 : drop_q + SEQ_W'(lost && drop_q != '1);
    seq_d = seq_q + SEQ_W'(qual);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      seq_q <= '0;
      drop_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      seq_q <= seq_d;
      drop_q <= drop_d;
    end
  end
  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we_i (push),
    .wa_i (wr_q),
    .wd_i (rec),
    .ra_i (rd_q),
    .rd_o (out_rec_o)
  );
  assign out_valid_o = cnt_q != '0;
  assign empty_o = cnt_q == '0;
  assign full_o = full;
  assign count_o = cnt_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed table, overflow/flush/wrap sequences and random traffic checked
// against a queue-based model of the trace buffer.
module tb_cpu_trace_buffer;
  import trace_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic cap_valid = 0, flush = 0, rdy = 0;
  trace_mode_e mode = OFF;
  logic [31:0] pc = 0, npc = 0, alu = 0, mem = 0, st = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic out_valid, full, empty, out_valid4, full4, empty4;
  trace_rec_t out_rec, out_rec4;
  logic [4:0] count, count4;
  logic [15:0] drop_cnt;
  logic [3:0] drop_cnt4;
  int n_chk = 0, n_fail = 0;
  trace_rec_t mq[$];
  int unsigned mseq = 0, mdrop = 0, mdrop4 = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer dut (
    .clk(clk), .rst(rst), .cap_valid_i(cap_valid), .cap_pc_i(pc), .cap_next_pc_i(npc),
    .cap_rs1_i(rs1), .cap_rs2_i(rs2), .cap_rd_i(rd), .cap_alu_i(alu), .cap_mem_data_i(mem),
    .cap_store_data_i(st), .mode_i(mode), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(rdy), .out_rec_o(out_rec), .count_o(count), .full_o(full), .empty_o(empty),
    .drop_cnt_o(drop_cnt));

  cpu_trace_buffer #(.SEQ_W(4)) dut4 (
    .clk(clk), .rst(rst), .cap_valid_i(cap_valid), .cap_pc_i(pc), .cap_next_pc_i(npc),
    .cap_rs1_i(rs1), .cap_rs2_i(rs2), .cap_rd_i(rd), .cap_alu_i(alu), .cap_mem_data_i(mem),
    .cap_store_data_i(st), .mode_i(mode), .flush_i(flush), .out_valid_o(out_valid4),
    .out_ready_i(rdy), .out_rec_o(out_rec4), .count_o(count4), .full_o(full4), .empty_o(empty4),
    .drop_cnt_o(drop_cnt4));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bump_drop();
    if (mdrop < 65535) mdrop++;
    if (mdrop4 < 15) mdrop4++;
  endtask

  task automatic model_update();
    trace_rec_t r;
    logic [31:0] seq_pc;
    bit qual, popm;
    if (rst) begin
      mq.delete();
      mseq = 0;
      mdrop = 0;
      mdrop4 = 0;
      return;
    end
    seq_pc = pc + 32'd4;
    qual = cap_valid && mode != OFF && (mode != FLOW || npc != seq_pc);
    popm = mq.size() > 0 && rdy;
    if (flush) begin
      mq.delete();
      mdrop = 0;
      mdrop4 = 0;
    end else begin
      if (popm) void'(mq.pop_front());
      if (qual) begin
        r = '{pc: pc, next_pc: npc, rs1: rs1, rs2: rs2, rd: rd, alu: alu, mem_data: mem,
              store_data: st, seq: mseq[15:0]};
        if (mq.size() < 16) mq.push_back(r);
        else if (mode == RING) begin
          void'(mq.pop_front());
          mq.push_back(r);
          bump_drop();
        end else bump_drop();
      end
    end
    if (qual) mseq = (mseq + 1) % 65536;
  endtask

  task automatic drive(input logic v, input trace_mode_e m, input logic [31:0] p, np,
                       input logic r, f);
    cap_valid = v; mode = m; pc = p; npc = np; rdy = r; flush = f;
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    alu = $urandom; mem = $urandom; st = $urandom;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    drive(0, OFF, 0, 0, 0, 0);
    rst = 0;
  endtask

  task automatic check_model();
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == 16);
    chk("valid", out_valid, mq.size() != 0);
    chk("drop", drop_cnt, mdrop);
    chk("drop4", drop_cnt4, mdrop4);
    if (mq.size() > 0) begin
      n_chk++;
      if (out_rec !== mq[0]) begin
        n_fail++;
        $display("FAIL head_rec: got %h expected %h", out_rec, mq[0]);
      end
      chk("seq4", out_rec4.seq, mq[0].seq & 16'hF);
    end
  endtask

  typedef struct {
    logic r, v, f, rdy;
    trace_mode_e m;
    logic [31:0] p, np;
    int cnt, drop;
    logic [31:0] hpc;
    int hseq;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, OFF,    32'h0,  32'h0,  0, 0, 32'h0,   0};
    tbl[1]  = '{0, 1, 0, 0, STREAM, 32'h0,  32'h4,  1, 0, 32'h0,   0};
    tbl[2]  = '{0, 1, 0, 0, STREAM, 32'h4,  32'h8,  2, 0, 32'h0,   0};
    tbl[3]  = '{0, 1, 0, 0, STREAM, 32'h8,  32'hC,  3, 0, 32'h0,   0};
    tbl[4]  = '{0, 0, 0, 1, STREAM, 32'h0,  32'h0,  2, 0, 32'h4,   1};
    tbl[5]  = '{0, 0, 0, 1, STREAM, 32'h0,  32'h0,  1, 0, 32'h8,   2};
    tbl[6]  = '{0, 0, 0, 1, STREAM, 32'h0,  32'h0,  0, 0, 32'h0,   0};
    tbl[7]  = '{1, 0, 0, 0, OFF,    32'h0,  32'h0,  0, 0, 32'h0,   0};
    tbl[8]  = '{0, 1, 0, 0, FLOW,   32'h10, 32'h14, 0, 0, 32'h0,   0};
    tbl[9]  = '{0, 1, 0, 0, FLOW,   32'h14, 32'h40, 1, 0, 32'h14,  0};
    tbl[10] = '{0, 1, 0, 0, FLOW,   32'h40, 32'h44, 1, 0, 32'h14,  0};
    tbl[11] = '{0, 1, 0, 0, OFF,    32'h50, 32'h90, 1, 0, 32'h14,  0};
    tbl[12] = '{0, 1, 1, 0, STREAM, 32'h100, 32'h104, 0, 0, 32'h0, 0};
    tbl[13] = '{0, 1, 0, 0, STREAM, 32'h200, 32'h204, 1, 0, 32'h200, 2};
    tbl[14] = '{0, 1, 0, 0, RING,   32'h204, 32'h208, 2, 0, 32'h200, 2};
    tbl[15] = '{0, 1, 0, 0, FLOW,   32'hFFFF_FFFC, 32'h0, 2, 0, 32'h200, 2};

    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_drop", drop_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r;
      drive(tbl[i].v, tbl[i].m, tbl[i].p, tbl[i].np, tbl[i].rdy, tbl[i].f);
      rst = 0;
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].drop);
      if (tbl[i].cnt > 0) begin
        chk($sformatf("tbl%0d_pc", i), out_rec.pc, tbl[i].hpc);
        chk($sformatf("tbl%0d_seq", i), out_rec.seq, tbl[i].hseq);
      end
    end

    do_reset();
    for (int i = 0; i < 20; i++) drive(1, STREAM, 32'(i * 4), 32'(i * 4 + 4), 0, 0);
    chk("stream_full", full, 1);
    chk("stream_drop", drop_cnt, 4);
    for (int i = 0; i < 16; i++) begin
      chk("stream_drain_seq", out_rec.seq, i);
      drive(0, STREAM, 0, 0, 1, 0);
    end
    chk("stream_empty", empty, 1);
    drive(1, STREAM, 32'h80, 32'h84, 0, 0);
    chk("stream_next_seq", out_rec.seq, 20);

    do_reset();
    for (int i = 0; i < 20; i++) drive(1, RING, 32'(i * 4), 32'(i * 4 + 4), 0, 0);
    chk("ring_count", count, 16);
    chk("ring_drop", drop_cnt, 4);
    for (int i = 4; i < 20; i++) begin
      chk("ring_drain_seq", out_rec.seq, i);
      drive(0, RING, 0, 0, 1, 0);
    end
    chk("ring_empty", empty, 1);

    do_reset();
    for (int i = 0; i < 16; i++) drive(1, STREAM, 32'(i * 4), 32'(i * 4 + 4), 0, 0);
    drive(1, STREAM, 32'h40, 32'h44, 1, 0);
    chk("pushpop_count", count, 16);
    chk("pushpop_drop", drop_cnt, 0);
    chk("pushpop_head", out_rec.seq, 1);
    drive(1, STREAM, 32'h44, 32'h48, 0, 1);
    chk("flush_count", count, 0);
    chk("flush_drop", drop_cnt, 0);
    drive(1, STREAM, 32'h48, 32'h4C, 0, 0);
    chk("flush_next_seq", out_rec.seq, 18);

    do_reset();
    for (int i = 0; i < 36; i++) drive(1, STREAM, 32'(i * 4), 32'(i * 4 + 4), 0, 0);
    chk("sat_drop16", drop_cnt, 20);
    chk("sat_drop4", drop_cnt4, 15);
    chk("sat_full4", full4, 1);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, STREAM, 32'(i * 4), 32'(i * 4 + 4), 1, 0);
      chk("wrap_seq4", out_rec4.seq, i % 16);
      chk("wrap_count4", count4, 1);
    end

    do_reset();
    for (int e = 0; e < 12; e++) begin
      int pct;
      pct = $urandom_range(5, 95);
      for (int c = 0; c < 250; c++) begin
        logic [31:0] p;
        check_model();
        p = $urandom;
        rst = $urandom_range(0, 499) == 0;
        drive($urandom_range(0, 99) < 80, trace_mode_e'($urandom_range(0, 3)), p,
              $urandom_range(0, 1) ? p + 32'd4 : 32'($urandom),
              $urandom_range(0, 99) < pct, $urandom_range(0, 59) == 0);
        rst = 0;
      end
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
